// File: rtl/bp_be_stride_prefetch_scheduler_pkg.sv
// Shared types for the backend stride prefetch scheduler.
// The descriptor struct depends on module widths, so it is declared through a macro.
`define DECLARE_BP_BE_LOOP_DESC_S(vaddr_width_mp, stride_width_mp, iters_width_mp) \
    typedef struct packed { \
        logic [vaddr_width_mp-1:0]  pc; \
        logic [vaddr_width_mp-1:0]  eff_addr; \
        logic [stride_width_mp-1:0] stride; \
        logic [iters_width_mp-1:0]  iters; \
    } bp_be_loop_desc_s

package bp_be_pkg;

    typedef enum logic [1:0] {
        e_pf_idle,
        e_pf_issue,
        e_pf_drain
    } bp_be_pf_sched_state_e;

endpackage

// File: rtl/bp_be_stride_prefetch_scheduler_credit_counter.sv
// Saturating up/down counter tracking free prefetch slots in the cache.
// Starts full; a simultaneous increment and decrement leaves it unchanged.
module bp_be_pf_credit_counter
    import bp_be_pkg::*;
#(
    parameter int max_inflight_p = 4,
    localparam int credit_width_lp = $clog2(max_inflight_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       inc_i,
    input  logic                       dec_i,
    output logic [credit_width_lp-1:0] credits_o,
    output logic                       full_o,
    output logic                       empty_o
);

    logic [credit_width_lp-1:0] credits_r;

    assign credits_o = credits_r;
    assign full_o    = (credits_r == credit_width_lp'(max_inflight_p));
    assign empty_o   = (credits_r == '0);

    // Returns beyond the maximum are dropped, which absorbs stale completions after reset.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            credits_r <= credit_width_lp'(max_inflight_p);
        end else if (inc_i & ~dec_i & ~full_o) begin
            credits_r <= credits_r + credit_width_lp'(1);
        end else if (dec_i & ~inc_i & ~empty_o) begin
            credits_r <= credits_r - credit_width_lp'(1);
        end
    end

endmodule

// File: rtl/bp_be_stride_prefetch_scheduler.sv
// Turns one inferred striding loop into a train of D-cache prefetches running
// prefetch_distance_p iterations ahead, credit-throttled and line-deduplicated.
module bp_be_stride_prefetch_scheduler
    import bp_be_pkg::*;
#(
    parameter int vaddr_width_p        = 39,
    parameter int stride_width_p       = 8,
    parameter int output_range_p       = 8,
    parameter int max_inflight_p       = 4,
    parameter int prefetch_distance_p  = 2,
    parameter int max_prefetches_p     = 32,
    parameter int block_offset_width_p = 6
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      enable_i,
    input  logic                      flush_i,
    input  logic                      loop_v_i,
    input  logic [vaddr_width_p-1:0]  loop_pc_i,
    input  logic [vaddr_width_p-1:0]  loop_eff_addr_i,
    input  logic [stride_width_p-1:0] loop_stride_i,
    input  logic [output_range_p-1:0] loop_iters_i,
    output logic                      loop_yumi_o,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_vaddr_o,
    output logic [vaddr_width_p-1:0]  pf_pc_o,
    input  logic                      pf_ready_and_i,
    input  logic                      pf_done_i,
    output logic                      busy_o
);

    `DECLARE_BP_BE_LOOP_DESC_S(vaddr_width_p, stride_width_p, output_range_p);

    localparam int line_width_lp   = vaddr_width_p - block_offset_width_p;
    localparam int credit_width_lp = $clog2(max_inflight_p + 1);
    localparam logic [output_range_p-1:0] max_pf_lp = output_range_p'(max_prefetches_p);

    // Handshakes: the descriptor moves when loop_v_i & loop_yumi_o (yumi is a pure
    // function of state and inputs); a prefetch moves when pf_v_o & pf_ready_and_i,
    // and pf_vaddr_o/pf_pc_o hold while pf_v_o waits unless a flush intervenes.
    bp_be_loop_desc_s desc_li;
    assign desc_li = '{pc: loop_pc_i, eff_addr: loop_eff_addr_i,
                       stride: loop_stride_i, iters: loop_iters_i};

    bp_be_pf_sched_state_e      state_r;
    logic [vaddr_width_p-1:0]   addr_r, stride_r, pc_r;
    logic [output_range_p-1:0]  cnt_r;
    logic [line_width_lp-1:0]   last_line_r;
    logic                       last_line_v_r;

    logic [credit_width_lp-1:0] credits;
    logic                       credits_full, credits_empty;

    logic [vaddr_width_p-1:0]   stride_sext, addr_init;
    logic [output_range_p-1:0]  cnt_init;
    logic                       issue, dup, pf_hs, advance, drain_done;

    assign stride_sext = {{(vaddr_width_p-stride_width_p){desc_li.stride[stride_width_p-1]}},
                          desc_li.stride};
    assign addr_init   = desc_li.eff_addr + stride_sext * vaddr_width_p'(prefetch_distance_p);
    assign cnt_init    = (desc_li.iters > max_pf_lp) ? max_pf_lp : desc_li.iters;

    // Flush masks the request in the same cycle so no credit is spent on an aborted train.
    assign issue   = (state_r == e_pf_issue) & ~flush_i;
    assign dup     = last_line_v_r & (addr_r[vaddr_width_p-1:block_offset_width_p] == last_line_r);
    assign pf_v_o  = issue & ~dup & ~credits_empty;
    assign pf_hs   = pf_v_o & pf_ready_and_i;
    assign advance = issue & (dup | pf_hs);

    assign pf_vaddr_o  = addr_r;
    assign pf_pc_o     = pc_r;
    assign loop_yumi_o = (state_r == e_pf_idle) & enable_i & loop_v_i & ~flush_i;
    assign busy_o      = (state_r != e_pf_idle);

    // A completion arriving on the last missing credit releases DRAIN in the same cycle.
    assign drain_done = credits_full
                      | (pf_done_i & (credits == credit_width_lp'(max_inflight_p - 1)));

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r       <= e_pf_idle;
            addr_r        <= '0;
            stride_r      <= '0;
            pc_r          <= '0;
            cnt_r         <= '0;
            last_line_r   <= '0;
            last_line_v_r <= 1'b0;
        end else begin
            case (state_r)
                e_pf_idle: begin
                    if (loop_yumi_o) begin
                        addr_r        <= addr_init;
                        stride_r      <= stride_sext;
                        pc_r          <= desc_li.pc;
                        cnt_r         <= cnt_init;
                        last_line_v_r <= 1'b0;
                        state_r       <= (cnt_init == '0) ? e_pf_drain : e_pf_issue;
                    end
                end
                e_pf_issue: begin
                    if (flush_i) begin
                        cnt_r   <= '0;
                        state_r <= e_pf_drain;
                    end else if (advance) begin
                        addr_r <= addr_r + stride_r;
                        cnt_r  <= cnt_r - output_range_p'(1);
                        if (pf_hs) begin
                            last_line_r   <= addr_r[vaddr_width_p-1:block_offset_width_p];
                            last_line_v_r <= 1'b1;
                        end
                        if (cnt_r == output_range_p'(1)) begin
                            state_r <= e_pf_drain;
                        end
                    end
                end
                e_pf_drain: begin
                    if (drain_done) begin
                        state_r <= e_pf_idle;
                    end
                end
                default: state_r <= e_pf_idle;
            endcase
        end
    end

    bp_be_pf_credit_counter #(
        .max_inflight_p(max_inflight_p)
    ) credit_counter (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .inc_i    (pf_done_i),
        .dec_i    (pf_hs),
        .credits_o(credits),
        .full_o   (credits_full),
        .empty_o  (credits_empty)
    );

endmodule

// File: tb/tb_bp_be_stride_prefetch_scheduler.sv
// Bench for the stride prefetch scheduler: descriptor table, hand-written corner
// sequences and random trains checked against a per-iteration address model.
module tb_bp_be_stride_prefetch_scheduler;

    localparam int VW   = 39;
    localparam int SW   = 8;
    localparam int RW   = 8;
    localparam int MAXI = 4;
    localparam int DIST = 2;
    localparam int MAXP = 32;
    localparam int BW   = 6;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, enable, flush, loop_v;
    logic [VW-1:0] loop_pc, loop_eff;
    logic [SW-1:0] loop_stride;
    logic [RW-1:0] loop_iters;
    logic          loop_yumi, pf_v, pf_ready, pf_done, busy;
    logic [VW-1:0] pf_vaddr, pf_pc;

    bp_be_stride_prefetch_scheduler dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .enable_i       (enable),
        .flush_i        (flush),
        .loop_v_i       (loop_v),
        .loop_pc_i      (loop_pc),
        .loop_eff_addr_i(loop_eff),
        .loop_stride_i  (loop_stride),
        .loop_iters_i   (loop_iters),
        .loop_yumi_o    (loop_yumi),
        .pf_v_o         (pf_v),
        .pf_vaddr_o     (pf_vaddr),
        .pf_pc_o        (pf_pc),
        .pf_ready_and_i (pf_ready),
        .pf_done_i      (pf_done),
        .busy_o         (busy)
    );

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;
    logic [2*VW-1:0] exp_q[$];
    logic [VW-1:0]   got_q[$];
    int outstanding = 0;
    int hs_cnt = 0;

    typedef struct {
        logic [VW-1:0] eff;
        logic [SW-1:0] stride;
        logic [RW-1:0] iters;
        int            exp_n;
        logic [VW-1:0] exp_first;
        logic [VW-1:0] exp_last;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected requests: one per iteration whose line differs from the last line requested.
    task automatic model_load(input logic [VW-1:0] pc, input logic [VW-1:0] eff,
                              input logic [SW-1:0] stride, input logic [RW-1:0] iters);
        int n;
        int st;
        logic [VW-1:0]    a;
        logic [VW-BW-1:0] last;
        bit have;
        n = (int'(iters) < MAXP) ? int'(iters) : MAXP;
        st = int'($signed(stride));
        have = 0;
        last = '0;
        for (int k = 0; k < n; k++) begin
            a = eff + VW'(longint'(st) * longint'(DIST + k));
            if (!have || a[VW-1:BW] != last) begin
                exp_q.push_back({pc, a});
                last = a[VW-1:BW];
                have = 1;
            end
        end
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic step();
        logic [2*VW-1:0] e;
        @(negedge clk);
        if (pf_v && pf_ready) begin
            hs_cnt++;
            got_q.push_back(pf_vaddr);
            check("credit_bound", 64'(outstanding < MAXI), 64'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_req: got 0x%0h, expected no request", pf_vaddr);
            end else begin
                e = exp_q.pop_front();
                check("req_addr", 64'(pf_vaddr), 64'(e[VW-1:0]));
                check("req_pc", 64'(pf_pc), 64'(e[2*VW-1:VW]));
            end
            outstanding++;
        end
        if (pf_done && outstanding > 0) outstanding--;
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic start_desc(input logic [VW-1:0] pc, input logic [VW-1:0] eff,
                              input logic [SW-1:0] stride, input logic [RW-1:0] iters);
        loop_pc = pc;
        loop_eff = eff;
        loop_stride = stride;
        loop_iters = iters;
        loop_v = 1'b1;
        enable = 1'b1;
        flush = 1'b0;
        pf_done = 1'b0;
        @(negedge clk);
        check("desc_yumi", 64'(loop_yumi), 64'd1);
        @(posedge clk);
        #1;
        loop_v = 1'b0;
    endtask

    task automatic finish_train(input int ready_pct, input int done_pct);
        int cyc = 0;
        while (busy && cyc < 3000) begin
            pf_ready = ($urandom_range(99) < ready_pct);
            pf_done = (outstanding > 0) && ($urandom_range(99) < done_pct);
            step();
            cyc++;
        end
        pf_done = 1'b0;
        check("train_timeout", 64'(cyc < 3000), 64'd1);
        check("drain_credits", 64'(outstanding), 64'd0);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_desc(input logic [VW-1:0] pc, input logic [VW-1:0] eff,
                            input logic [SW-1:0] stride, input logic [RW-1:0] iters,
                            input int ready_pct, input int done_pct);
        got_q.delete();
        exp_q.delete();
        model_load(pc, eff, stride, iters);
        start_desc(pc, eff, stride, iters);
        finish_train(ready_pct, done_pct);
    endtask

    initial begin
        vecs[0] = '{39'h1000, 8'd64,  8'd3,   3,  39'h1080, 39'h1100};
        vecs[1] = '{39'h2000, 8'd8,   8'd10,  2,  39'h2010, 39'h2040};
        vecs[2] = '{39'h40,   8'hC0,  8'd3,   3,  39'h7F_FFFF_FFC0, 39'h7F_FFFF_FF40};
        vecs[3] = '{39'h3000, 8'd64,  8'd0,   0,  39'h0, 39'h0};
        vecs[4] = '{39'h4000, 8'd0,   8'd5,   1,  39'h4000, 39'h4000};
        vecs[5] = '{39'h5000, 8'd64,  8'd200, 32, 39'h5080, 39'h5840};
        vecs[6] = '{39'h100,  8'h7F,  8'd2,   2,  39'h1FE, 39'h27D};
        vecs[7] = '{39'h1000, 8'hFF,  8'd4,   1,  39'hFFE, 39'hFFE};

        reset_n = 1'b0;
        enable = 1'b0;
        flush = 1'b0;
        loop_v = 1'b0;
        loop_pc = '0;
        loop_eff = '0;
        loop_stride = '0;
        loop_iters = '0;
        pf_ready = 1'b0;
        pf_done = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_pf_v", 64'(pf_v), 64'd0);
        check("reset_yumi", 64'(loop_yumi), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_vaddr", 64'(pf_vaddr), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // idle gating: enable low and flush both block yumi
        loop_v = 1'b1;
        loop_iters = 8'd3;
        enable = 1'b0;
        #1 check("enable_low_blocks", 64'(loop_yumi), 64'd0);
        enable = 1'b1;
        flush = 1'b1;
        #1 check("flush_idle_blocks", 64'(loop_yumi), 64'd0);
        step();
        check("idle_after_blocked", 64'(busy), 64'd0);
        flush = 1'b0;
        loop_v = 1'b0;

        // descriptor table
        for (int i = 0; i < 8; i++) begin
            run_desc(39'h40_0000 + VW'(i * 4), vecs[i].eff, vecs[i].stride, vecs[i].iters, 100, 100);
            check("vec_count", 64'(got_q.size()), 64'(vecs[i].exp_n));
            if (vecs[i].exp_n > 0 && got_q.size() > 0) begin
                check("vec_first", 64'(got_q[0]), 64'(vecs[i].exp_first));
                check("vec_last", 64'(got_q[got_q.size()-1]), 64'(vecs[i].exp_last));
            end
        end

        // credit throttle
        exp_q.delete();
        model_load(39'h123, 39'h1000, 8'd64, 8'd8);
        start_desc(39'h123, 39'h1000, 8'd64, 8'd8);
        pf_ready = 1'b1;
        hs_cnt = 0;
        repeat (8) step();
        check("throttle_4", 64'(hs_cnt), 64'd4);
        check("throttle_v_low", 64'(pf_v), 64'd0);
        check("throttle_addr_held", 64'(pf_vaddr), 64'h1180);
        pf_done = 1'b1;
        hs_cnt = 0;
        step();
        pf_done = 1'b0;
        repeat (5) step();
        check("throttle_release_1", 64'(hs_cnt), 64'd1);
        finish_train(100, 100);

        // flush under backpressure with credits outstanding
        exp_q.delete();
        model_load(39'h456, 39'h1000, 8'd64, 8'd8);
        start_desc(39'h456, 39'h1000, 8'd64, 8'd8);
        pf_ready = 1'b1;
        step();
        step();
        pf_ready = 1'b0;
        step();
        check("bp_valid", 64'(pf_v), 64'd1);
        check("bp_addr", 64'(pf_vaddr), 64'h1100);
        step();
        check("bp_addr_stable", 64'(pf_vaddr), 64'h1100);
        flush = 1'b1;
        pf_ready = 1'b1;
        hs_cnt = 0;
        step();
        check("flush_no_hs", 64'(hs_cnt), 64'd0);
        check("flush_to_drain", 64'(busy), 64'd1);
        flush = 1'b0;
        exp_q.delete();
        loop_v = 1'b1;
        loop_iters = 8'd0;
        check("drain_blocks_yumi", 64'(loop_yumi), 64'd0);
        pf_done = 1'b1;
        flush = 1'b1;
        step();
        pf_done = 1'b0;
        flush = 1'b0;
        check("drain_blocks_yumi_2", 64'(loop_yumi), 64'd0);
        check("drain_waits_credit", 64'(busy), 64'd1);
        pf_done = 1'b1;
        step();
        pf_done = 1'b0;
        check("idle_after_credits", 64'(busy), 64'd0);
        check("yumi_after_drain", 64'(loop_yumi), 64'd1);
        step();
        loop_v = 1'b0;
        check("iters0_drain", 64'(busy), 64'd1);
        step();
        check("iters0_idle", 64'(busy), 64'd0);

        // reset mid-train, then a stale completion must not create an extra credit
        exp_q.delete();
        model_load(39'h789, 39'h1000, 8'd64, 8'd8);
        start_desc(39'h789, 39'h1000, 8'd64, 8'd8);
        pf_ready = 1'b1;
        step();
        step();
        reset_n = 1'b0;
        step();
        check("midreset_pf_v", 64'(pf_v), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_yumi", 64'(loop_yumi), 64'd0);
        check("midreset_vaddr", 64'(pf_vaddr), 64'd0);
        check("midreset_pc", 64'(pf_pc), 64'd0);
        reset_n = 1'b1;
        outstanding = 0;
        exp_q.delete();
        pf_done = 1'b1;
        step();
        pf_done = 1'b0;
        model_load(39'h9AB, 39'h3000, 8'd64, 8'd6);
        start_desc(39'h9AB, 39'h3000, 8'd64, 8'd6);
        pf_ready = 1'b1;
        hs_cnt = 0;
        repeat (8) step();
        check("saturate_4", 64'(hs_cnt), 64'd4);
        finish_train(100, 100);

        // random trains
        for (int r = 0; r < 40; r++) begin
            logic [VW-1:0] rpc, reff;
            logic [SW-1:0] rstride;
            logic [RW-1:0] riters;
            rpc = VW'({$urandom(), $urandom()});
            reff = VW'({$urandom(), $urandom()});
            rstride = SW'($urandom_range(255));
            if ($urandom_range(2) == 0) rstride = SW'($urandom_range(24)) - SW'(12);
            riters = ($urandom_range(7) == 0) ? RW'($urandom_range(255)) : RW'($urandom_range(40));
            run_desc(rpc, reff, rstride, riters, 70, 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_be_stride_prefetch_scheduler.md
Name: bp_be_stride_prefetch_scheduler

Overview:
- Consumes one loop descriptor at a time from the loop-inference block: striding load PC, current effective address, signed stride and remaining-iteration estimate.
- Sequences a train of prefetch requests into the D-cache prefetch port, running `prefetch_distance_p` iterations ahead of the load.
- Throttles the train with in-flight credits, suppresses duplicate same-line requests, and aborts cleanly on pipeline flush.
- Sits in bp_be_checker, between the loop-inference output handshake and the cache prefetch request port.

Parameters:
- vaddr_width_p, 39, virtual address width
- stride_width_p, 8, signed stride width
- output_range_p, 8, iteration-count width
- max_inflight_p, 4, maximum outstanding prefetches (credits)
- prefetch_distance_p, 2, iterations ahead of current address for first request
- max_prefetches_p, 32, cap on requests per descriptor
- block_offset_width_p, 6, cache-line offset bits, used for duplicate suppression

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; synchronous, active-low
- enable_i  in  1  accept new descriptors when high
- flush_i  in  1  abort current train
- loop_v_i  in  1  descriptor valid
- loop_pc_i  in  vaddr_width_p  striding load PC
- loop_eff_addr_i  in  vaddr_width_p  current effective address
- loop_stride_i  in  stride_width_p  signed stride, in bytes
- loop_iters_i  in  output_range_p  remaining iterations
- loop_yumi_o  out  1  descriptor consumed
- pf_v_o  out  1  prefetch request valid
- pf_vaddr_o  out  vaddr_width_p  prefetch address
- pf_pc_o  out  vaddr_width_p  originating load PC (tag)
- pf_ready_and_i  in  1  cache accepts request
- pf_done_i  in  1  one outstanding prefetch completed; returns a credit
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (reset_n_i low at a clock edge):
  - state=IDLE; pf_v_o=0; loop_yumi_o=0; busy_o=0.
  - credits=max_inflight_p; last_line_v=0.
  - Address, count and PC registers cleared.
- Descriptor handshake:
  - loop_yumi_o = (state==IDLE) & enable_i & loop_v_i & ~flush_i, combinational.
  - On yumi, at the next edge:
    - addr_r = loop_eff_addr_i + sext(loop_stride_i)*prefetch_distance_p, modulo 2^vaddr_width_p.
    - stride_r = sext(stride).
    - pc_r = loop_pc_i.
    - cnt_r = min(loop_iters_i, max_prefetches_p).
    - last_line_v=0.
  - If cnt_r would be 0, go straight to DRAIN; otherwise go to ISSUE.
- States: IDLE, ISSUE, DRAIN.
- ISSUE, evaluated each cycle:
  - dup = last_line_v & (addr_r[vaddr_width_p-1:block_offset_width_p] == last_line_r).
  - If dup:
    - pf_v_o=0.
    - At the edge: addr_r+=stride_r, cnt_r-=1. No credit is consumed.
  - Else:
    - pf_v_o = (credits!=0).
    - pf_vaddr_o=addr_r; pf_pc_o=pc_r.
  - On pf_v_o & pf_ready_and_i:
    - addr_r+=stride_r; cnt_r-=1; credits-=1.
    - last_line_r=addr_r line; last_line_v=1.
  - pf_vaddr_o is stable while pf_v_o is high and no handshake has occurred. The only exception is flush.
  - When cnt_r reaches 0 (after the final decrement), go to DRAIN.
  - Stride 0: the first request issues; every following iteration is dup. Result is exactly 1 request.
- DRAIN:
  - pf_v_o=0.
  - Go to IDLE when credits==max_inflight_p, including on the same cycle's pf_done_i return.
- Credits:
  - Each edge: credits += pf_done_i − (request handshake).
  - Simultaneous done and handshake leaves credits unchanged.
  - pf_done_i at credits==max_inflight_p is ignored (saturate); no underflow is possible.
- flush_i:
  - From ISSUE, the next state is DRAIN and cnt_r is cleared.
  - pf_v_o is forced to 0 in the flush cycle; no handshake counts that cycle.
  - Outstanding credits still return in DRAIN.
  - Flush in IDLE blocks yumi; flush in DRAIN has no effect.
- enable_i low only blocks new descriptors. An active train completes.
- Reset mid-train: all state is discarded. Credits reinitialize to max_inflight_p; late pf_done_i pulses are ignored by saturation.
- Address arithmetic wraps modulo 2^vaddr_width_p; negative strides are supported.

Decomposition:
- bp_be_pkg:
  - bp_be_pf_sched_state_e {e_pf_idle, e_pf_issue, e_pf_drain}.
  - Descriptor struct bp_be_loop_desc_s {pc, eff_addr, stride, iters}, declared via a width-parameterized macro.
- One sub-module, bp_be_pf_credit_counter:
  - Up/down saturating counter, reset value max_inflight_p.
  - Ports: inc_i, dec_i, credits_o, full_o, empty_o.

Test Plan:
- Basic train: eff_addr=0x1000, stride=64, iters=3, distance=2, ready always 1.
  - Requests 0x1080, 0x10C0, 0x1100 on 3 consecutive cycles.
  - After all 3 done pulses, busy_o drops.
- Credit throttle: iters=8, ready=1, no pf_done_i.
  - Exactly 4 requests, then pf_v_o=0 with addr held.
  - A single pf_done_i releases exactly 1 further request.
- Dedup: stride=8, eff_addr=0x2000, iters=10.
  - Requests only at line boundaries: 0x2010 and 0x2040 (first address of each new line).
  - 8 of the 10 iterations are suppressed; all 10 are counted.
- Negative wrap: eff_addr=0x40, stride=-64 (0xC0), iters=3.
  - Requests 0x7F_FFFF_FFC0, 0x7F_FFFF_FF80, 0x7F_FFFF_FF40.
- Flush and backpressure: flush_i during ISSUE with pf_v_o=1 and ready=0.
  - pf_v_o=0 that cycle; state goes to DRAIN.
  - New loop_v_i is not yumi'd until all credits return.
- Edge descriptors: iters=0 produces yumi and no requests, back to IDLE. Reset asserted mid-train leaves all outputs 0 on the following cycle.
